// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: keyboard events to snake direction, pause and a per-tick turn queue
module snake_dir_ctrl #(
    parameter int DEPTH = 2,
    parameter logic [1:0] INIT_DIR = 2'd1
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic makeBreak,
    input  logic [7:0] outCode,
    input  logic tick,
    output logic [1:0] dir,
    output logic paused,
    output logic move,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic dropped
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [1:0] q [DEPTH];
    logic [PW-1:0] rd, wr, newest;
    logic [7:0] last_key;
    logic is_dir, mapped, accept, space, step, pop, full, legal, push, drop, flush;
    logic [1:0] cand, ref_dir;
    always_comb begin
        is_dir  = outCode == 8'h1D || outCode == 8'h23 || outCode == 8'h1B || outCode == 8'h1C;
        cand    = outCode == 8'h1D ? 2'd0 : outCode == 8'h23 ? 2'd1 : outCode == 8'h1B ? 2'd2 : 2'd3;
        mapped  = is_dir || outCode == 8'h29;
        accept  = valid && makeBreak && mapped && outCode != last_key;
        space   = accept && outCode == 8'h29;
        newest  = wr == '0 ? PW'(DEPTH - 1) : wr - 1'b1;
        ref_dir = q_count != '0 ? q[newest] : dir;
        step    = tick && !paused;
        pop     = step && q_count != '0;
        full    = q_count == CW'(DEPTH);
        legal   = accept && is_dir && !paused && cand != ref_dir && cand != (ref_dir ^ 2'd2);
        push    = legal && (!full || pop);
        drop    = legal && full && !pop;
        flush   = space && !paused;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            dir      <= INIT_DIR;
            paused   <= 1'b0;
            move     <= 1'b0;
            dropped  <= 1'b0;
            q_count  <= '0;
            last_key <= '0;
            rd       <= '0;
            wr       <= '0;
        end else begin
            move    <= step;
            dropped <= drop;
            if (pop)
                dir <= q[rd];
            if (space)
                paused <= !paused;
            if (accept)
                last_key <= outCode;
            else if (valid && !makeBreak && outCode == last_key)
                last_key <= '0;
            if (flush) begin
                rd      <= '0;
                wr      <= '0;
                q_count <= '0;
            end else begin
                if (push)
                    wr <= wr == PW'(DEPTH - 1) ? '0 : wr + 1'b1;
                if (pop)
                    rd <= rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1;
                q_count <= q_count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk)
        if (push)
            q[wr] <= cand;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed scenarios plus random events against a queue-based model
module tb_snake_dir_ctrl;
    localparam int DEPTH = 2;
    logic clk = 1'b0, reset = 1'b0, valid = 1'b0, makeBreak = 1'b0, tick = 1'b0;
    logic [7:0] outCode = '0;
    logic [1:0] dir;
    logic paused, move, dropped;
    logic [$clog2(DEPTH+1)-1:0] q_count;
    int total = 0, passed = 0;
    int m_dir, m_last;
    bit m_paused, m_move, m_drop;
    int mq[$];
    logic [7:0] codes [6] = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h29, 8'h00};

    snake_dir_ctrl #(.DEPTH(DEPTH), .INIT_DIR(2'd1)) dut (
        .clk(clk), .reset(reset), .valid(valid), .makeBreak(makeBreak), .outCode(outCode),
        .tick(tick), .dir(dir), .paused(paused), .move(move), .q_count(q_count), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model(input bit v, input bit mb, input logic [7:0] code, input bit t);
        int c, r;
        bit acc, stp, want, popped;
        c = code == 8'h1D ? 0 : code == 8'h23 ? 1 : code == 8'h1B ? 2 : code == 8'h1C ? 3 : -1;
        acc = v && mb && (c >= 0 || code == 8'h29) && int'(code) != m_last;
        stp = t && !m_paused;
        m_move = stp;
        m_drop = 0;
        r = mq.size() > 0 ? mq[$] : m_dir;
        want = acc && c >= 0 && !m_paused && c != r && (c ^ 2) != r;
        popped = stp && mq.size() > 0;
        if (popped) m_dir = mq.pop_front();
        if (want) begin
            if (mq.size() < DEPTH) mq.push_back(c);
            else m_drop = 1;
        end
        if (acc && code == 8'h29) begin
            if (!m_paused) mq.delete();
            m_paused = !m_paused;
        end
        if (acc) m_last = code;
        else if (v && !mb && int'(code) == m_last) m_last = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dir"}, dir, m_dir);
        chk({tag, ".paused"}, paused, m_paused);
        chk({tag, ".move"}, move, m_move);
        chk({tag, ".q_count"}, q_count, mq.size());
        chk({tag, ".dropped"}, dropped, m_drop);
    endtask

    task automatic cyc(input string tag, input bit v, input bit mb, input logic [7:0] code, input bit t);
        valid = v; makeBreak = mb; outCode = code; tick = t;
        model(v, mb, code, t);
        @(posedge clk); #1;
        valid = 0; tick = 0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1; valid = 0; tick = 0;
        m_dir = 1; m_last = 0; m_paused = 0; m_move = 0; m_drop = 0; mq.delete();
        @(posedge clk); #1;
        reset = 0;
        check_all(tag);
    endtask

    task automatic key(input string tag, input logic [7:0] code); cyc(tag, 1, 1, code, 0); endtask
    task automatic rel(input string tag, input logic [7:0] code); cyc(tag, 1, 0, code, 0); endtask
    task automatic tk(input string tag); cyc(tag, 0, 0, 8'h00, 1); endtask

    initial begin
        do_reset("rst");
        chk("rst_dir", dir, 1);
        chk("rst_q", q_count, 0);
        key("t1_up", 8'h1D);
        chk("t1_q", q_count, 1);
        tk("t1_tick");
        chk("t1_dir", dir, 0);
        chk("t1_move", move, 1);
        cyc("t1_idle", 0, 0, 8'h00, 0);
        chk("t1_move_off", move, 0);

        do_reset("t2_rst");
        key("t2_left", 8'h1C);
        chk("t2_q", q_count, 0);
        chk("t2_drop", dropped, 0);
        tk("t2_tick");
        chk("t2_dir", dir, 1);
        chk("t2_move", move, 1);

        do_reset("t3_rst");
        for (int i = 0; i < 4; i++) key("t3_hold", 8'h1D);
        chk("t3_q", q_count, 1);
        rel("t3_rel", 8'h1D);
        key("t3_repress", 8'h1D);
        chk("t3_q2", q_count, 1);

        do_reset("t4_rst");
        key("t4_up", 8'h1D); rel("t4_r1", 8'h1D);
        key("t4_left", 8'h1C); rel("t4_r2", 8'h1C);
        key("t4_down", 8'h1B);
        chk("t4_q", q_count, 2);
        chk("t4_drop", dropped, 1);
        rel("t4_r3", 8'h1B);
        chk("t4_drop_off", dropped, 0);
        tk("t4_tk1"); chk("t4_dir1", dir, 0);
        tk("t4_tk2"); chk("t4_dir2", dir, 3);
        tk("t4_tk3"); chk("t4_dir3", dir, 3);

        do_reset("t5_rst");
        key("t5_up", 8'h1D);
        cyc("t5_both", 1, 1, 8'h1C, 1);
        chk("t5_dir", dir, 0);
        chk("t5_q", q_count, 1);
        tk("t5_tk"); chk("t5_dir2", dir, 3);

        do_reset("t6_rst");
        key("t6_up", 8'h1D);
        key("t6_pause", 8'h29);
        chk("t6_paused", paused, 1);
        chk("t6_q", q_count, 0);
        tk("t6_tk"); chk("t6_move", move, 0);
        key("t6_right", 8'h23); chk("t6_q2", q_count, 0);
        key("t6_resume", 8'h29); chk("t6_paused2", paused, 0);
        tk("t6_tk2"); chk("t6_move2", move, 1);

        do_reset("rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
            else cyc("rnd", $urandom_range(0, 1), $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) == 0 ? 8'($urandom) : codes[$urandom_range(0, 5)],
                     $urandom_range(0, 3) == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Turns decoded PS/2 keyboard events (valid, makeBreak, outCode) into the snake's movement direction and pause state for the Snakes game. It filters typematic repeats and illegal reversals, and buffers quick successive turns in a small queue. It releases one turn per game tick so rapid key presses are neither lost nor applied twice in one step. It sits between the keyboard decoder and the game-board update logic.

Parameters:
DEPTH, 2, number of pending turn entries in the queue (≥1)
INIT_DIR, 2'd1, direction loaded at reset (0 up, 1 right, 2 down, 3 left)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
valid  in  1  decoder event strobe, one cycle per event
makeBreak  in  1  1 = make (press), 0 = break (release); qualified by valid
outCode  in  8  scan code of the event
tick  in  1  game-step strobe, one cycle
dir  out  2  current applied direction
paused  out  1  game paused flag
move  out  1  one-cycle pulse: snake advances this step
q_count  out  $clog2(DEPTH+1)  pending queue entries
dropped  out  1  one-cycle pulse: a legal turn was discarded because the queue was full

Behaviour:
- Key map: 1D=W→up(0), 23=D→right(1), 1B=S→down(2), 1C=A→left(3), 29=space→pause toggle. All other codes are ignored, and last_key is left unchanged.
- Repeat filter: register last_key (8b, reset 0).
  - A make with outCode==last_key is ignored.
  - An accepted make of a mapped key sets last_key=outCode.
  - A break (valid & ~makeBreak) with outCode==last_key clears last_key to 0. Other breaks are ignored.
- Pause: an accepted space make toggles paused. Entering pause flushes the queue (q_count→0). While paused, direction makes update last_key but are not queued.
- Turn acceptance (not paused, accepted direction make, candidate c):
  - Reference r = newest queued entry if q_count>0, else dir.
  - Reject if c==r or c==(r^2) (no-op and reversal). No dropped pulse on rejection.
  - Otherwise push. If the queue is full and no pop occurs this cycle, discard the turn and pulse dropped the next cycle.
- Step: on tick & ~paused:
  - If q_count>0, dir<=head and pop.
  - move pulses high the next cycle, together with the new dir. Latency from tick to visible dir and move is 1 cycle.
  - tick while paused: no move, dir and queue unchanged.
- Same-cycle push and pop:
  - The pop takes the old head.
  - The push evaluates r from the pre-pop queue contents.
  - The push is accepted even if the queue was full, because the pop frees a slot. q_count stays unchanged.
- Same-cycle space make and tick: the pause toggle and the step are both evaluated using the pre-edge value of paused.
- Queue: circular buffer with rd/wr pointers wrapping at DEPTH, plus a count.
- Reset values: dir=INIT_DIR, paused=0, move=0, dropped=0, q_count=0, last_key=0, pointers 0. Reset mid-operation discards all pending turns.
- valid low: makeBreak and outCode are don't-care.

Test Plan:
- Reset → dir=1, paused=0, q_count=0, move=0. Then valid/make 1D, then tick → dir=0 one cycle after tick, move=1 for exactly 1 cycle.
- dir=1 (right), make 1C (left) → rejected: q_count=0, dropped=0. Then tick → dir stays 1, move=1.
- Hold 1D, i.e. make 1D repeated 4× with no break → q_count=1 only. Then break 1D, make 1D again → treated as a new press; rejected because r=0, so q_count stays 1.
- dir=1, DEPTH=2: make 1D (up), break, make 1C (left), break, make 1B (down) → q_count=2, dropped pulses on the 3rd. Then ticks → dir 0, then 3, then stays 3.
- Queue holding 1 entry (up) with dir=1; make 1C in the same cycle as tick → dir=0, queue holds left, q_count=1.
- Make 29 with q_count=1 → paused=1, q_count=0. Ticks → move=0. Make 23 is ignored. Make 29 again → paused=0, and the next tick gives move=1.
